// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and entry type for the reorder buffer
package rob_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ARCH_REG_W = 5;
    localparam int DATA_WIDTH = 64;
    typedef struct packed {
        logic valid;
        logic ready;
        logic regWrite;
        logic [ARCH_REG_W-1:0] destReg;
    } robEntry_t;
endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrap-around pointer with increment and synchronous clear
module rob_ptr #(
    parameter int DEPTH = 32,
    parameter int W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) ptr <= '0;
        else if (clear) ptr <= '0;
        else if (inc) ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: allocates rename tags, captures writebacks and retires in
// program order, clearing map-table entries whose latest producer retires.
module reorder_buffer #(
    parameter int ROBsize = 32,
    parameter int mapValueSize = $clog2(ROBsize + 1),
    parameter int DATA_WIDTH = rob_pkg::DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid_i,
    input  logic [rob_pkg::ARCH_REG_W-1:0]    alloc_destReg_i,
    input  logic                              alloc_regWrite_i,
    output logic                              alloc_ready_o,
    output logic [mapValueSize-1:0]           alloc_tag_o,
    input  logic                              wb_valid_i,
    input  logic [mapValueSize-1:0]           wb_tag_i,
    input  logic [DATA_WIDTH-1:0]             wb_value_i,
    input  logic [mapValueSize-1:0]           rdTag1_i,
    input  logic [mapValueSize-1:0]           rdTag2_i,
    output logic                              rdReady1_o,
    output logic                              rdReady2_o,
    output logic [DATA_WIDTH-1:0]             rdValue1_o,
    output logic [DATA_WIDTH-1:0]             rdValue2_o,
    output logic                              commit_valid_o,
    output logic                              commit_regWrite_o,
    output logic [rob_pkg::ARCH_REG_W-1:0]    commit_destReg_o,
    output logic [DATA_WIDTH-1:0]             commit_value_o,
    output logic [rob_pkg::ARCH_REG_W-1:0]    commitReadAddr_o,
    input  logic [mapValueSize-1:0]           commitReadData_i,
    output logic [rob_pkg::NUM_ARCH_REGS-1:0] resets_o,
    input  logic                              flush_i
);
    import rob_pkg::*;
    localparam int PTR_W = $clog2(ROBsize);
    robEntry_t entry [ROBsize];
    logic [DATA_WIDTH-1:0] value [ROBsize];
    logic [PTR_W-1:0] head, tail, wbIdx;
    logic [mapValueSize-1:0] count;
    logic allocFire, wbHit;
    robEntry_t headEntry;

    assign headEntry = entry[head];
    assign wbIdx = PTR_W'(wb_tag_i - mapValueSize'(1));
    assign wbHit = wb_valid_i && wb_tag_i != '0 && wb_tag_i <= mapValueSize'(ROBsize) && entry[wbIdx].valid;
    assign alloc_ready_o = count != mapValueSize'(ROBsize);
    assign allocFire = alloc_valid_i && alloc_ready_o && !flush_i;
    assign alloc_tag_o = mapValueSize'(tail) + mapValueSize'(1);
    assign commit_valid_o = headEntry.valid && headEntry.ready && !flush_i;
    assign commit_regWrite_o = commit_valid_o && headEntry.regWrite;
    assign commit_destReg_o = headEntry.destReg;
    assign commitReadAddr_o = headEntry.destReg;
    assign commit_value_o = value[head];

    // Only clear the map entry if this retiring instruction is still its latest producer
    always_comb
        resets_o = flush_i ? '1 :
                   (commit_regWrite_o && commitReadData_i == mapValueSize'(head) + mapValueSize'(1)) ?
                   NUM_ARCH_REGS'(1) << commit_destReg_o : '0;

    function automatic logic [DATA_WIDTH:0] readOperand(input logic [mapValueSize-1:0] tag);
        logic [PTR_W-1:0] idx;
        idx = PTR_W'(tag - mapValueSize'(1));
        if (tag == '0) return {1'b1, {DATA_WIDTH{1'b0}}};
        if (wbHit && wb_tag_i == tag) return {1'b1, wb_value_i};
        if (tag > mapValueSize'(ROBsize)) return '0;
        return {entry[idx].valid && entry[idx].ready, value[idx]};
    endfunction

    always_comb begin
        {rdReady1_o, rdValue1_o} = readOperand(rdTag1_i);
        {rdReady2_o, rdValue2_o} = readOperand(rdTag2_i);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < ROBsize; i++) begin
                entry[i] <= '0;
                value[i] <= '0;
            end
        end else if (flush_i) begin
            count <= '0;
            for (int i = 0; i < ROBsize; i++) entry[i] <= '0;
        end else begin
            count <= count + mapValueSize'(allocFire) - mapValueSize'(commit_valid_o);
            if (wbHit) begin
                entry[wbIdx].ready <= 1'b1;
                value[wbIdx] <= wb_value_i;
            end
            if (commit_valid_o) entry[head] <= '0;
            if (allocFire) entry[tail] <= '{valid: 1'b1, ready: 1'b0, regWrite: alloc_regWrite_i, destReg: alloc_destReg_i};
        end

    rob_ptr #(.DEPTH(ROBsize), .W(PTR_W)) headPtr (
        .clk(clk), .reset(reset), .clear(flush_i), .inc(commit_valid_o), .ptr(head)
    );
    rob_ptr #(.DEPTH(ROBsize), .W(PTR_W)) tailPtr (
        .clk(clk), .reset(reset), .clear(flush_i), .inc(allocFire), .ptr(tail)
    );
endmodule
